// File: rtl/led_pulse_stretch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared types and clock constants for the LED pulse stretcher.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } stretch_state_t;

  localparam int CLK_HZ          = 125_000_000;
  localparam int DEFAULT_HOLD_MS = 100;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pulse_stretch_if.sv
`default_nettype none
// ============================================================================
// Module      : led_pulse_stretch_if
// Description : Event-in / LED-out bundle between event logic and the stretcher.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_pulse_stretch_if #(
  parameter int N_CH = 4
);

  logic            enable;
  logic [N_CH-1:0] pulse_in;
  logic            clear_missed;
  logic [N_CH-1:0] led_out;
  logic            busy;
  logic [N_CH-1:0] missed;

  modport master (
    output enable, pulse_in, clear_missed,
    input  led_out, busy, missed
  );

  modport slave (
    input  enable, pulse_in, clear_missed,
    output led_out, busy, missed
  );

endinterface
`default_nettype wire

// File: rtl/led_pulse_stretch_ch.sv
`default_nettype none
// ============================================================================
// Module      : led_stretch_ch
// Description : One LED channel: IDLE/HOLD FSM, hold down-counter, missed flag.
// Revision    : 1.0 - initial release
// ============================================================================
module led_stretch_ch
  import led_pkg::*;
#(
  parameter int HOLD_CYCLES = 12_500_000,
  parameter int RETRIGGER   = 1
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic enable,
  input  wire logic pulse_in,
  input  wire logic clear_missed,
  output logic      led_out,
  output logic      led_next,
  output logic      missed
);

  localparam int            CW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] c_reload = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] c_one    = CW'(1);

  stretch_state_t r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_led;
  logic           r_missed;

  stretch_state_t w_state_next;
  logic [CW-1:0]  w_cnt_next;
  logic           w_event;
  logic           w_terminal;
  logic           w_drop;
  logic           w_led_next;
  logic           w_missed_next;

  assign w_event    = enable & pulse_in;
  assign w_terminal = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_led    <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_led    <= w_led_next;
      r_missed <= w_missed_next;
    end
  end

  // The terminal cycle counts as a free channel, so even in no-retrigger mode
  // an event there reloads instead of being dropped.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_drop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_event) begin
          w_state_next = HOLD;
          w_cnt_next   = c_reload;
        end
      end
      HOLD: begin
        if (w_event && ((RETRIGGER != 0) || w_terminal)) begin
          w_cnt_next = c_reload;
        end else begin
          w_drop = w_event;
          if (w_terminal) begin
            w_state_next = IDLE;
          end else begin
            w_cnt_next = r_cnt - c_one;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // A drop in the same cycle as clear_missed leaves the flag set.
  always_comb begin
    w_led_next    = (w_state_next == HOLD);
    w_missed_next = w_drop | (r_missed & ~clear_missed);
  end

  assign led_out  = r_led;
  assign led_next = w_led_next;
  assign missed   = r_missed;

endmodule
`default_nettype wire

// File: rtl/led_pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module      : led_pulse_stretch
// Description : N_CH independent event-to-LED pulse stretchers plus busy flag.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pulse_stretch
  import led_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int HOLD_CYCLES = ms_to_cycles(DEFAULT_HOLD_MS),
  parameter int RETRIGGER   = 1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  led_pulse_stretch_if.slave bus
);

  logic [N_CH-1:0] w_led;
  logic [N_CH-1:0] w_led_next;
  logic [N_CH-1:0] w_missed;
  logic            r_busy;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      led_stretch_ch #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .RETRIGGER   (RETRIGGER)
      ) u_ch (
        .clk          (clk),
        .reset        (reset),
        .enable       (bus.enable),
        .pulse_in     (bus.pulse_in[i]),
        .clear_missed (bus.clear_missed),
        .led_out      (w_led[i]),
        .led_next     (w_led_next[i]),
        .missed       (w_missed[i])
      );
    end
  endgenerate

  // Built from next-state LEDs so busy lines up with led_out cycle for cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= |w_led_next;
    end
  end

  assign bus.led_out = w_led;
  assign bus.busy    = r_busy;
  assign bus.missed  = w_missed;

endmodule
`default_nettype wire

// File: tb/tb_led_pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pulse_stretch
// Description : Directed table plus random stimulus against a remaining-time model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pulse_stretch;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [3:0] pulse;
    logic       clr;
    logic [3:0] led_rt1;
    logic [3:0] led_rt0;
    logic [3:0] miss_rt0;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_pulse_stretch_if #(.N_CH(4)) if_a ();
  led_pulse_stretch_if #(.N_CH(4)) if_b ();
  led_pulse_stretch_if #(.N_CH(4)) if_c ();

  led_pulse_stretch #(.N_CH(4), .HOLD_CYCLES(4), .RETRIGGER(1)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a));
  led_pulse_stretch #(.N_CH(4), .HOLD_CYCLES(4), .RETRIGGER(0)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b));
  led_pulse_stretch #(.N_CH(4), .HOLD_CYCLES(1), .RETRIGGER(0)) dut_c (
    .clk(clk), .reset(reset), .bus(if_c));

  int n_checks = 0;
  int n_errors = 0;

  // Model: rem = cycles the LED still has to stay lit, from the next cycle on.
  int         hold_k [3] = '{4, 4, 1};
  int         rt_k   [3] = '{1, 0, 0};
  int         rem    [3][4];
  logic [3:0] mm     [3];

  vec_t vq[$];

  task automatic check(input string name, input int k, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d @%0t: got %b, expected %b", name, k, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] act_led(input int k);
    case (k)
      0:       return if_a.led_out;
      1:       return if_b.led_out;
      default: return if_c.led_out;
    endcase
  endfunction

  function automatic logic [3:0] act_miss(input int k);
    case (k)
      0:       return if_a.missed;
      1:       return if_b.missed;
      default: return if_c.missed;
    endcase
  endfunction

  function automatic logic act_busy(input int k);
    case (k)
      0:       return if_a.busy;
      1:       return if_b.busy;
      default: return if_c.busy;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic en, input logic [3:0] p, input logic clr);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        logic ev;
        logic set;
        ev  = en & p[i];
        set = 1'b0;
        if (r) begin
          rem[k][i] = 0;
          mm[k][i]  = 1'b0;
        end else begin
          if (ev && (rt_k[k] != 0 || rem[k][i] <= 1)) begin
            rem[k][i] = hold_k[k];
          end else begin
            if (ev && rem[k][i] > 1) set = 1'b1;
            if (rem[k][i] > 0) rem[k][i]--;
          end
          mm[k][i] = set | (mm[k][i] & ~clr);
        end
      end
    end
  endtask

  task automatic do_cycle(input logic r, input logic en, input logic [3:0] p, input logic clr);
    reset = r;
    if_a.enable = en; if_a.pulse_in = p; if_a.clear_missed = clr;
    if_b.enable = en; if_b.pulse_in = p; if_b.clear_missed = clr;
    if_c.enable = en; if_c.pulse_in = p; if_c.clear_missed = clr;
    @(posedge clk);
    model_step(r, en, p, clr);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      logic [3:0] exp_led;
      for (int i = 0; i < 4; i++) exp_led[i] = (rem[k][i] > 0);
      check("model_led",    k, act_led(k),           exp_led);
      check("model_busy",   k, {3'b0, act_busy(k)},  {3'b0, |exp_led});
      check("model_missed", k, act_miss(k),          mm[k]);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      mm[k] = 4'b0;
      for (int i = 0; i < 4; i++) rem[k][i] = 0;
    end
    reset = 1'b1;
    if_a.enable = 1'b0; if_a.pulse_in = 4'b0; if_a.clear_missed = 1'b0;
    if_b.enable = 1'b0; if_b.pulse_in = 4'b0; if_b.clear_missed = 1'b0;
    if_c.enable = 1'b0; if_c.pulse_in = 4'b0; if_c.clear_missed = 1'b0;

    // rst en pulse clr | led(rt=1) led(rt=0) missed(rt=0), seen the cycle after
    vq.push_back(vec_t'{1'b1, 1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000});
    vq.push_back(vec_t'{1'b1, 1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000});
    // single pulse
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000});
    // pulses at t, t+2 (drop in rt=0), t+4 (terminal), t+6 with clear
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0001});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0001});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0001});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0001});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0001});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1'b1, 4'b0001, 4'b0001, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000});
    // enable low ignores events; dropping enable mid-hold lets it finish
    vq.push_back(vec_t'{1'b0, 1'b0, 4'b1010, 1'b0, 4'b0000, 4'b0000, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b0, 4'b1010, 1'b0, 4'b0000, 4'b0000, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0100, 1'b0, 4'b0100, 4'b0100, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1'b0, 4'b0100, 4'b0100, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0100, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0100, 4'b0100, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000});
    // reset mid-hold, then a fresh hold
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b1000, 1'b0, 4'b1000, 4'b1000, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1'b0, 4'b1000, 4'b1000, 4'b0000});
    vq.push_back(vec_t'{1'b1, 1'b1, 4'b1000, 1'b0, 4'b0000, 4'b0000, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b1000, 1'b0, 4'b1000, 4'b1000, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1'b0, 4'b1000, 4'b1000, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1'b0, 4'b1000, 4'b1000, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1'b0, 4'b1000, 4'b1000, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000});
    // all channels at once, then a drop on every channel, then reset clears missed
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b1111, 1'b0, 4'b1111, 4'b1111, 4'b0000});
    vq.push_back(vec_t'{1'b0, 1'b1, 4'b1111, 1'b0, 4'b1111, 4'b1111, 4'b1111});
    vq.push_back(vec_t'{1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000});

    foreach (vq[n]) begin
      do_cycle(vq[n].rst, vq[n].en, vq[n].pulse, vq[n].clr);
      check($sformatf("tbl%0d_led", n),    0, if_a.led_out, vq[n].led_rt1);
      check($sformatf("tbl%0d_busy", n),   0, {3'b0, if_a.busy}, {3'b0, |vq[n].led_rt1});
      check($sformatf("tbl%0d_missed", n), 0, if_a.missed, 4'b0000);
      check($sformatf("tbl%0d_led", n),    1, if_b.led_out, vq[n].led_rt0);
      check($sformatf("tbl%0d_busy", n),   1, {3'b0, if_b.busy}, {3'b0, |vq[n].led_rt0});
      check($sformatf("tbl%0d_missed", n), 1, if_b.missed, vq[n].miss_rt0);
    end

    // HOLD_CYCLES=1 back-to-back events stay continuously high
    for (int n = 0; n < 3; n++) begin
      do_cycle(1'b0, 1'b1, 4'b0010, 1'b0);
      check("h1_continuous", 2, if_c.led_out, 4'b0010);
    end
    do_cycle(1'b0, 1'b1, 4'b0000, 1'b0);
    check("h1_release", 2, if_c.led_out, 4'b0000);

    for (int n = 0; n < 600; n++) begin
      logic       r;
      logic       en;
      logic [3:0] p;
      logic       clr;
      r   = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 4) != 0);
      p   = 4'($urandom) & 4'($urandom);
      clr = ($urandom_range(0, 9) == 0);
      do_cycle(r, en, p, clr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
